mef_embalagem: RTL and testbench

MEF_EMBALAGEM -- requirements
Module: mef_embalagem

---
 rtl/mef_embalagem.sv | 140 ++++++++++++++
 tb/tb_mef_embalagem.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mef_embalagem.sv
// Packing-station controller: fills boxes with approved bottles, seals and pushes them onto a
// pallet, buffering bottles that arrive while no box can take them.
module mef_embalagem #(
  parameter int unsigned GARRAFAS_POR_CAIXA = 12,
  parameter int unsigned CAIXAS_POR_PALETE  = 10,
  parameter int unsigned TIMEOUT_LACRE      = 8,
  parameter int unsigned BUF_MAX            = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       garrafa_ok,
  input  logic       caixa_presente,
  input  logic       lacre_done,
  input  logic       palete_troca,
  output logic       pede_caixa,
  output logic       lacrar,
  output logic       empurrar,
  output logic       palete_cheio,
  output logic       bloquear,
  output logic       alarme,
  output logic [3:0] cont_garrafas,
  output logic [3:0] cont_caixas
);

  localparam int unsigned BufW = (BUF_MAX < 1) ? 1 : $clog2(BUF_MAX + 1);

  localparam logic [3:0]      GarrafasMax = 4'(GARRAFAS_POR_CAIXA);
  localparam logic [3:0]      CaixasMax   = 4'(CAIXAS_POR_PALETE);
  localparam logic [3:0]      TimerLast   = 4'(TIMEOUT_LACRE - 1);
  localparam logic [BufW-1:0] BufMax      = BufW'(BUF_MAX);

  typedef enum logic [2:0] {
    StEsperaCaixa,
    StEnchendo,
    StLacrando,
    StEmpurrando,
    StPaleteCheio,
    StErro
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      garrafas_q, garrafas_d;
  logic [3:0]      caixas_q, caixas_d;
  logic [3:0]      timer_q, timer_d;
  logic [BufW-1:0] buf_q, buf_d;

  logic fill, drain, direct, stored, lost, fault;

  always_comb begin
    state_d    = state_q;
    garrafas_d = garrafas_q;
    caixas_d   = caixas_q;
    timer_d    = timer_q;
    buf_d      = buf_q;

    // A bottle enters the box only while the box is really at the station.
    fill   = (state_q == StEnchendo) && caixa_presente;
    drain  = fill && (buf_q != '0);
    direct = fill && (buf_q == '0) && garrafa_ok;
    stored = garrafa_ok && !direct && (state_q != StErro);
    lost   = stored && !drain && (buf_q == BufMax);
    fault  = lost || ((state_q == StEnchendo) && !caixa_presente);

    if (fault) begin
      state_d = StErro;
    end else begin
      if (stored && !drain) begin
        buf_d = buf_q + 1'b1;
      end else if (drain && !stored) begin
        buf_d = buf_q - 1'b1;
      end

      unique case (state_q)
        StEsperaCaixa: begin
          if (caixa_presente) state_d = StEnchendo;
        end
        StEnchendo: begin
          if (drain || direct) begin
            garrafas_d = garrafas_q + 4'd1;
            if (garrafas_q + 4'd1 == GarrafasMax) begin
              state_d = StLacrando;
              timer_d = 4'd0;
            end
          end
        end
        StLacrando: begin
          // lacre_done wins over a timeout on the same cycle.
          if (lacre_done) begin
            state_d = StEmpurrando;
          end else if (timer_q == TimerLast) begin
            state_d = StErro;
          end else begin
            timer_d = timer_q + 4'd1;
          end
        end
        StEmpurrando: begin
          garrafas_d = 4'd0;
          caixas_d   = caixas_q + 4'd1;
          state_d    = (caixas_q + 4'd1 == CaixasMax) ? StPaleteCheio : StEsperaCaixa;
        end
        StPaleteCheio: begin
          if (palete_troca) begin
            state_d  = StEsperaCaixa;
            caixas_d = 4'd0;
          end
        end
        StErro: state_d = StErro;
        default: state_d = StErro;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StEsperaCaixa;
      garrafas_q <= 4'd0;
      caixas_q   <= 4'd0;
      timer_q    <= 4'd0;
      buf_q      <= '0;
    end else begin
      state_q    <= state_d;
      garrafas_q <= garrafas_d;
      caixas_q   <= caixas_d;
      timer_q    <= timer_d;
      buf_q      <= buf_d;
    end
  end

  always_comb begin
    pede_caixa    = (state_q == StEsperaCaixa);
    lacrar        = (state_q == StLacrando);
    empurrar      = (state_q == StEmpurrando);
    palete_cheio  = (state_q == StPaleteCheio);
    alarme        = (state_q == StErro);
    bloquear      = (state_q == StErro) || (buf_q == BufMax);
    cont_garrafas = garrafas_q;
    cont_caixas   = caixas_q;
  end

endmodule

// File: tb/tb_mef_embalagem.sv
// Bench for mef_embalagem: directed scenarios with literal expectations plus randomized traffic,
// every cycle compared against a behavioural model of the packing station.
module tb_mef_embalagem;

  localparam int G  = 12;
  localparam int C  = 10;
  localparam int TO = 8;
  localparam int BM = 2;

  localparam int M_ESPERA = 0;
  localparam int M_ENCH   = 1;
  localparam int M_LACR   = 2;
  localparam int M_EMP    = 3;
  localparam int M_CHEIO  = 4;
  localparam int M_ERRO   = 5;

  logic       clk = 1'b0;
  logic       reset, garrafa_ok, caixa_presente, lacre_done, palete_troca;
  logic       pede_caixa, lacrar, empurrar, palete_cheio, bloquear, alarme;
  logic [3:0] cont_garrafas, cont_caixas;

  int n_checks = 0;
  int n_errors = 0;

  // Model: spec phase, bottles in box, boxes on pallet, buffered bottles, sealing cycles spent.
  int m_st, m_g, m_c, m_b, m_t;

  mef_embalagem #(
    .GARRAFAS_POR_CAIXA(G),
    .CAIXAS_POR_PALETE (C),
    .TIMEOUT_LACRE     (TO),
    .BUF_MAX           (BM)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .garrafa_ok    (garrafa_ok),
    .caixa_presente(caixa_presente),
    .lacre_done    (lacre_done),
    .palete_troca  (palete_troca),
    .pede_caixa    (pede_caixa),
    .lacrar        (lacrar),
    .empurrar      (empurrar),
    .palete_cheio  (palete_cheio),
    .bloquear      (bloquear),
    .alarme        (alarme),
    .cont_garrafas (cont_garrafas),
    .cont_caixas   (cont_caixas)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  // What the coming clock edge must do, from the station's rules.
  task automatic model_step(input bit r, input bit g, input bit cp, input bit ld, input bit pt);
    bit into_box, from_buf, lost;
    if (r) begin
      m_st = M_ESPERA; m_g = 0; m_c = 0; m_b = 0; m_t = 0;
      return;
    end
    if (m_st == M_ERRO) return;
    into_box = (m_st == M_ENCH) && cp && (m_b > 0 || g);
    from_buf = (m_st == M_ENCH) && cp && (m_b > 0);
    lost     = g && !(into_box && !from_buf) && !from_buf && (m_b == BM);
    if (lost || (m_st == M_ENCH && !cp)) begin
      m_st = M_ERRO;
      return;
    end
    if (from_buf) m_b = m_b - 1;
    if (g && !(into_box && !from_buf)) m_b = m_b + 1;
    case (m_st)
      M_ESPERA: if (cp) m_st = M_ENCH;
      M_ENCH: if (into_box) begin
        m_g++;
        if (m_g == G) begin m_st = M_LACR; m_t = 0; end
      end
      M_LACR: begin
        m_t++;
        if (ld) m_st = M_EMP;
        else if (m_t == TO) m_st = M_ERRO;
      end
      M_EMP: begin
        m_g = 0; m_c++;
        m_st = (m_c == C) ? M_CHEIO : M_ESPERA;
      end
      M_CHEIO: if (pt) begin m_st = M_ESPERA; m_c = 0; end
      default: ;
    endcase
  endtask

  task automatic compare_model();
    check("pede_caixa",    int'(pede_caixa),    int'(m_st == M_ESPERA));
    check("lacrar",        int'(lacrar),        int'(m_st == M_LACR));
    check("empurrar",      int'(empurrar),      int'(m_st == M_EMP));
    check("palete_cheio",  int'(palete_cheio),  int'(m_st == M_CHEIO));
    check("alarme",        int'(alarme),        int'(m_st == M_ERRO));
    check("bloquear",      int'(bloquear),      int'(m_st == M_ERRO || m_b == BM));
    check("cont_garrafas", int'(cont_garrafas), m_g);
    check("cont_caixas",   int'(cont_caixas),   m_c);
  endtask

  task automatic cyc(input bit r, input bit g, input bit cp, input bit ld, input bit pt);
    reset = r; garrafa_ok = g; caixa_presente = cp; lacre_done = ld; palete_troca = pt;
    model_step(r, g, cp, ld, pt);
    @(negedge clk);
    compare_model();
  endtask

  // From ESPERA_CAIXA with an empty buffer: present box and feed 12 bottles.
  task automatic fill_box();
    cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < G; i++) cyc(0, 1, 1, 0, 0);
  endtask

  task automatic full_box();
    fill_box();
    cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 1, 0, 0);
  endtask

  initial begin
    cyc(1, 0, 0, 0, 0);
    check("reset_pede", int'(pede_caixa), 1);
    check("reset_alarme", int'(alarme), 0);
    check("reset_bloquear", int'(bloquear), 0);
    check("reset_garrafas", int'(cont_garrafas), 0);

    // Box fill
    fill_box();
    check("fill_garrafas12", int'(cont_garrafas), 12);
    check("fill_lacrar", int'(lacrar), 1);
    cyc(0, 0, 1, 1, 0);
    check("fill_empurrar", int'(empurrar), 1);
    cyc(0, 0, 1, 0, 0);
    check("fill_empurrar_off", int'(empurrar), 0);
    check("fill_garrafas0", int'(cont_garrafas), 0);
    check("fill_caixas1", int'(cont_caixas), 1);
    check("fill_pede", int'(pede_caixa), 1);

    // Buffering
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    check("buf_bloquear", int'(bloquear), 1);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    check("buf_drain1_bloquear", int'(bloquear), 0);
    check("buf_drain1_garrafas", int'(cont_garrafas), 1);
    cyc(0, 0, 1, 0, 0);
    check("buf_drain2_garrafas", int'(cont_garrafas), 2);

    // Overflow during sealing
    cyc(1, 0, 0, 0, 0);
    fill_box();
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 1, 0, 0);
    check("ovf_bloquear_full", int'(bloquear), 1);
    check("ovf_still_lacrar", int'(lacrar), 1);
    cyc(0, 1, 1, 0, 0);
    check("ovf_alarme", int'(alarme), 1);
    check("ovf_bloquear", int'(bloquear), 1);
    for (int i = 0; i < 5; i++) cyc(0, 1, 1, 1, 1);
    check("ovf_sticky", int'(alarme), 1);

    // Seal timeout
    cyc(1, 0, 0, 0, 0);
    fill_box();
    for (int i = 0; i < TO - 1; i++) cyc(0, 0, 1, 0, 0);
    check("to_7_lacrar", int'(lacrar), 1);
    cyc(0, 0, 1, 0, 0);
    check("to_8_alarme", int'(alarme), 1);
    cyc(1, 0, 0, 0, 0);
    fill_box();
    for (int i = 0; i < TO - 1; i++) cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 1, 0);
    check("to_late_empurrar", int'(empurrar), 1);

    // Pallet
    cyc(1, 0, 0, 0, 0);
    for (int b = 0; b < C; b++) full_box();
    check("pal_cheio", int'(palete_cheio), 1);
    check("pal_caixas10", int'(cont_caixas), 10);
    cyc(0, 0, 0, 0, 1);
    check("pal_caixas0", int'(cont_caixas), 0);
    check("pal_pede", int'(pede_caixa), 1);

    // Reset mid-operation: 3 boxes, 7 bottles, one buffered
    cyc(1, 0, 0, 0, 0);
    for (int b = 0; b < 3; b++) full_box();
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    for (int i = 0; i < 7; i++) cyc(0, 1, 1, 0, 0);
    check("mid_garrafas7", int'(cont_garrafas), 7);
    check("mid_caixas3", int'(cont_caixas), 3);
    cyc(1, 1, 1, 1, 1);
    check("mid_garrafas0", int'(cont_garrafas), 0);
    check("mid_caixas0", int'(cont_caixas), 0);
    check("mid_pede", int'(pede_caixa), 1);
    check("mid_alarme", int'(alarme), 0);
    check("mid_bloquear", int'(bloquear), 0);

    // Randomized traffic
    for (int n = 0; n < 6000; n++) begin
      bit r, g, cp, ld, pt;
      r  = (m_st == M_ERRO) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 599) == 0);
      g  = ($urandom_range(0, 2) == 0);
      cp = (m_st == M_ESPERA) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 199) != 0);
      ld = ($urandom_range(0, 3) == 0);
      pt = ($urandom_range(0, 5) == 0);
      cyc(r, g, cp, ld, pt);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
